// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: byte-command transfer engine driving spiflash-style SPI/QSPI pins.
// Define SPI_XFER_DDR_EN to compile the DDR write/read (DWR/DRD) datapath.
module spi_xfer_engine #(
    parameter int CLK_DIV = 2,
    parameter int DUMMY_W = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       cmd_err,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic [3:0] flash_io_oe,
    output logic [3:0] flash_io_do,
    input  logic [3:0] flash_io_di
);

    localparam logic [2:0] OP_BEGIN = 3'd0;
    localparam logic [2:0] OP_END   = 3'd1;
    localparam logic [2:0] OP_SPI   = 3'd2;
    localparam logic [2:0] OP_QWR   = 3'd3;
    localparam logic [2:0] OP_QRD   = 3'd4;
    localparam logic [2:0] OP_DWR   = 3'd5;
    localparam logic [2:0] OP_DRD   = 3'd6;
    localparam logic [2:0] OP_DUMMY = 3'd7;

    localparam int            CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [7:0]    DUMMY_MASK = 8'((1 << DUMMY_W) - 1);

    typedef enum logic [2:0] {
        IDLE,
        GUARD,
        PH_LO,
        PH_HI,
        DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] div_cnt_q;
    logic [7:0]    nclk_q;
    logic          end2_q;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          cmd_err_q;
    logic          csb_q;
    logic          fclk_q;
    logic [3:0]    oe_q;
    logic [3:0]    do_q;

    logic [2:0]    op_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;

    logic          accept;
    logic          div_last;
    logic          drd_trail;
    logic          is_read;
    logic          sample;
    logic [7:0]    rx_d;
    logic [7:0]    nclk_d;
    logic [3:0]    oe_d;
    logic [3:0]    do_d;
    state_t        first_st_d;
    logic          op_unsup_d;

    assign accept   = (state_q == IDLE) && cmd_ready_q && cmd_valid;
    assign div_last = (div_cnt_q == DIV_LAST);

`ifdef SPI_XFER_DDR_EN
    assign drd_trail = (op_q == OP_DRD);
`else
    assign drd_trail = 1'b0;
`endif

    assign is_read = (op_q == OP_SPI) || (op_q == OP_QRD) || drd_trail;
    // Reads sample in the last cycle of the high half; DRD also in its trailing low half.
    assign sample  = div_last && (((state_q == PH_HI) && is_read) ||
                                  ((state_q == PH_LO) && drd_trail));
    assign rx_d    = (op_q == OP_SPI) ? {rx_q[6:0], flash_io_di[1]}
                                      : {rx_q[3:0], flash_io_di};

    always_comb begin
        nclk_d     = 8'd8;
        oe_d       = 4'b0000;
        do_d       = do_q;
        first_st_d = PH_LO;
        op_unsup_d = 1'b0;
        case (cmd_op)
            OP_SPI: begin
                oe_d = 4'b0001;
                do_d = {3'b000, cmd_data[7]};
            end
            OP_QWR: begin
                nclk_d = 8'd2;
                oe_d   = 4'b1111;
                do_d   = cmd_data[7:4];
            end
            OP_QRD: nclk_d = 8'd2;
`ifdef SPI_XFER_DDR_EN
            OP_DWR: begin
                nclk_d = 8'd1;
                oe_d   = 4'b1111;
                do_d   = cmd_data[7:4];
            end
            OP_DRD: begin
                nclk_d     = 8'd1;
                first_st_d = PH_HI;
            end
`else
            OP_DWR, OP_DRD: op_unsup_d = 1'b1;
`endif
            OP_DUMMY: nclk_d = cmd_data & DUMMY_MASK;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= cmd_op;
            tx_q <= cmd_data;
        end else if ((state_q == PH_HI) && div_last && (op_q == OP_SPI)) begin
            tx_q <= {tx_q[6:0], tx_q[7]};
        end
        if (sample) begin
            rx_q <= rx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            nclk_q      <= 8'd0;
            end2_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            cmd_err_q   <= 1'b0;
            csb_q       <= 1'b1;
            fclk_q      <= 1'b0;
            oe_q        <= 4'b0000;
            do_q        <= 4'b0000;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cmd_ready_q) begin
                        cmd_ready_q <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        div_cnt_q   <= '0;
                        end2_q      <= 1'b0;
                        state_q     <= DONE;
                        case (cmd_op)
                            OP_BEGIN: begin
                                if (csb_q) begin
                                    csb_q   <= 1'b0;
                                    state_q <= GUARD;
                                end
                            end
                            OP_END: begin
                                if (!csb_q) state_q <= GUARD;
                            end
                            default: begin
                                if (csb_q || op_unsup_d) begin
                                    cmd_err_q <= 1'b1;
                                end else begin
                                    oe_q   <= oe_d;
                                    do_q   <= do_d;
                                    nclk_q <= nclk_d;
                                    if (nclk_d != 8'd0) begin
                                        state_q <= first_st_d;
                                        fclk_q  <= (first_st_d == PH_HI);
                                    end
                                end
                            end
                        endcase
                    end
                end

                // END holds CS low for one guard period, then high for a second one.
                GUARD: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        if ((op_q == OP_END) && !end2_q) begin
                            end2_q <= 1'b1;
                            csb_q  <= 1'b1;
                            oe_q   <= 4'b0000;
                        end else begin
                            state_q <= DONE;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end

                PH_LO: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        state_q   <= PH_HI;
                        fclk_q    <= 1'b1;
`ifdef SPI_XFER_DDR_EN
                        if (op_q == OP_DWR) do_q <= tx_q[3:0];
                        if (op_q == OP_DRD) begin
                            state_q     <= DONE;
                            fclk_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rx_d;
                        end
`endif
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end

                PH_HI: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        fclk_q    <= 1'b0;
                        nclk_q    <= nclk_q - 8'd1;
                        state_q   <= PH_LO;
                        if ((nclk_q == 8'd1) && !drd_trail) begin
                            state_q <= DONE;
                            if (is_read) begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= rx_d;
                            end
                        end else if (op_q == OP_SPI) begin
                            do_q <= {3'b000, tx_q[6]};
                        end else if (op_q == OP_QWR) begin
                            do_q <= tx_q[3:0];
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign cmd_err     = cmd_err_q;
    assign flash_csb   = csb_q;
    assign flash_clk   = fclk_q;
    assign flash_io_oe = oe_q;
    assign flash_io_do = do_q;

endmodule
